// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing for the reorder buffer and its squash-mask helper.
package reorder_buffer_pkg;

  localparam int NUM_SUPER = 2;
  localparam int NUM_ROB   = 8;
  localparam int NUM_PR    = 64;
  localparam int NUM_FL    = 32;
  localparam int ROB_W     = $clog2(NUM_ROB);
  localparam int PR_W      = $clog2(NUM_PR);
  localparam int FL_W      = $clog2(NUM_FL);
  localparam int AR_W      = 5;
  localparam int CNT_W     = $clog2(NUM_SUPER + 1);

  localparam logic [PR_W-1:0] ZERO_PR  = PR_W'(31);
  localparam logic [AR_W-1:0] ZERO_REG = AR_W'(31);

  typedef struct packed {
    logic            valid;
    logic            complete;
    logic [AR_W-1:0] dest;
    logic [PR_W-1:0] T;
    logic [PR_W-1:0] Told;
    logic [FL_W-1:0] FL_idx;
  } ROB_ENTRY_t;

  typedef struct packed {
    logic [NUM_SUPER-1:0][AR_W-1:0] dest_idx;
    logic [NUM_SUPER-1:0]           dispatch_valid;
  } DECODER_ROB_OUT_t;

  typedef struct packed {
    logic [NUM_SUPER-1:0][PR_W-1:0] Told_idx;
  } ROB_FL_OUT_t;

  typedef struct packed {
    logic [NUM_SUPER-1:0][PR_W-1:0] T_idx;
    logic [NUM_SUPER-1:0][AR_W-1:0] dest_idx;
  } ROB_ARCH_MAP_OUT_t;

endpackage

// File: rtl/rob_squash_mask.sv
// Marks every slot strictly younger than the mispredicted branch and older
// than tail. Occupancy span is measured from head; head == tail is treated as
// a full buffer (an empty buffer has no valid entries, so the top's valid AND
// makes the empty case harmless).
module rob_squash_mask
  import reorder_buffer_pkg::*;
(
  input  logic [ROB_W-1:0]   head,
  input  logic [ROB_W-1:0]   tail,
  input  logic [ROB_W-1:0]   rollback_idx,
  output logic [NUM_ROB-1:0] mask
);

  logic [ROB_W:0]   span;
  logic [ROB_W-1:0] rb_off;
  logic [ROB_W-1:0] off;

  // Age-compare each slot against the branch, both as distances from head.
  always_comb begin
    span   = (tail == head) ? (ROB_W+1)'(NUM_ROB) : {1'b0, tail - head};
    rb_off = rollback_idx - head;
    off    = '0;
    mask   = '0;
    for (int i = 0; i < NUM_ROB; i++) begin
      off     = ROB_W'(i) - head;
      mask[i] = (off > rb_off) && ({1'b0, off} < span);
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate at tail, out-of-order complete,
// in-order retire at head (up to NUM_SUPER per cycle), branch rollback to tail.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           dispatch_en,
  input  logic [NUM_SUPER-1:0]           dispatch_valid,
  input  logic [NUM_SUPER-1:0][AR_W-1:0] dest_idx,
  input  logic [NUM_SUPER-1:0][PR_W-1:0] T_idx,
  input  logic [NUM_SUPER-1:0][PR_W-1:0] Told_idx,
  input  logic [NUM_SUPER-1:0][FL_W-1:0] FL_idx,
  input  logic [NUM_SUPER-1:0]           complete_en,
  input  logic [NUM_SUPER-1:0][ROB_W-1:0] complete_idx,
  input  logic                           rollback_en,
  input  logic [ROB_W-1:0]               rollback_idx,
  output logic                           ROB_valid,
  output logic [NUM_SUPER-1:0][ROB_W-1:0] ROB_idx,
  output logic [NUM_SUPER-1:0]           retire_en,
  output logic [NUM_SUPER-1:0][PR_W-1:0] retire_Told_idx,
  output logic [NUM_SUPER-1:0][PR_W-1:0] retire_T_idx,
  output logic [NUM_SUPER-1:0][AR_W-1:0] retire_dest_idx,
  output logic [FL_W-1:0]                FL_rollback_idx
);

  ROB_ENTRY_t [NUM_ROB-1:0]  entries;
  logic [ROB_W-1:0]          head, tail;
  logic [ROB_W:0]            count, count_nx;
  logic [ROB_W-1:0]          tail_nx;

  DECODER_ROB_OUT_t          dec;
  ROB_FL_OUT_t               fl_out;
  ROB_ARCH_MAP_OUT_t         arch_out;

  ROB_ENTRY_t [NUM_SUPER-1:0]            new_entry;
  logic [NUM_SUPER-1:0][ROB_W-1:0]       slot_ptr;
  logic [NUM_SUPER-1:0][ROB_W-1:0]       ret_ptr;
  logic [CNT_W-1:0]                      disp_cnt, ret_cnt;
  logic [NUM_ROB-1:0]                    squash, cmp_hit;
  logic [ROB_W-1:0]                      rb_span;
  logic [ROB_W:0]                        rb_count;
  logic                                  do_dispatch;
  logic                                  chain;

  assign dec.dest_idx       = dest_idx;
  assign dec.dispatch_valid = dispatch_valid;
  assign do_dispatch        = dispatch_en & ~rollback_en;

  assign ROB_idx         = slot_ptr;
  assign ROB_valid       = (count <= (ROB_W+1)'(NUM_ROB - 2));
  assign FL_rollback_idx = entries[rollback_idx].FL_idx;
  assign retire_Told_idx = fl_out.Told_idx;
  assign retire_T_idx    = arch_out.T_idx;
  assign retire_dest_idx = arch_out.dest_idx;

  rob_squash_mask u_squash (
    .head         (head),
    .tail         (tail),
    .rollback_idx (rollback_idx),
    .mask         (squash)
  );

  // Valid slots pack densely from tail; an idle slot 0 lets slot 1 take tail.
  always_comb begin
    disp_cnt  = '0;
    slot_ptr  = '0;
    new_entry = '0;
    for (int s = 0; s < NUM_SUPER; s++) begin
      slot_ptr[s]  = tail + ROB_W'(disp_cnt);
      new_entry[s] = '{valid: 1'b1, complete: 1'b0, dest: dec.dest_idx[s],
                       T: T_idx[s], Told: Told_idx[s], FL_idx: FL_idx[s]};
      if (dec.dispatch_valid[s]) disp_cnt = disp_cnt + CNT_W'(1);
    end
  end

  // Retire is a contiguous prefix from head; idle lanes park on the zero reg.
  always_comb begin
    chain             = ~reset;
    ret_cnt           = '0;
    retire_en         = '0;
    ret_ptr           = '0;
    fl_out.Told_idx   = '0;
    arch_out.T_idx    = '0;
    arch_out.dest_idx = '0;
    for (int l = 0; l < NUM_SUPER; l++) begin
      ret_ptr[l]           = head + ROB_W'(l);
      chain                = chain & entries[ret_ptr[l]].valid & entries[ret_ptr[l]].complete;
      retire_en[l]         = chain;
      fl_out.Told_idx[l]   = chain ? entries[ret_ptr[l]].Told : ZERO_PR;
      arch_out.T_idx[l]    = chain ? entries[ret_ptr[l]].T    : ZERO_PR;
      arch_out.dest_idx[l] = chain ? entries[ret_ptr[l]].dest : ZERO_REG;
      if (chain) ret_cnt = ret_cnt + CNT_W'(1);
    end
  end

  // Per-entry completion strobe from any CDB lane.
  always_comb begin
    cmp_hit = '0;
    for (int i = 0; i < NUM_ROB; i++)
      for (int l = 0; l < NUM_SUPER; l++)
        if (complete_en[l] && complete_idx[l] == ROB_W'(i)) cmp_hit[i] = 1'b1;
  end

  // Pointer/occupancy update; rollback count is 4 bits wide so a full buffer
  // rolling back at its youngest entry keeps all eight.
  always_comb begin
    rb_span  = rollback_idx - head;
    rb_count = {1'b0, rb_span} + (ROB_W+1)'(1);
    if (rollback_en) begin
      tail_nx  = rollback_idx + ROB_W'(1);
      count_nx = rb_count - (ROB_W+1)'(ret_cnt);
    end else begin
      tail_nx  = do_dispatch ? tail + ROB_W'(disp_cnt) : tail;
      count_nx = count + (do_dispatch ? (ROB_W+1)'(disp_cnt) : '0) - (ROB_W+1)'(ret_cnt);
    end
  end

  // Entry state: complete, then retire/squash invalidation, then allocation.
  always_ff @(posedge clock) begin
    if (reset) begin
      entries <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      for (int i = 0; i < NUM_ROB; i++) begin
        if (cmp_hit[i] && entries[i].valid && !(rollback_en && squash[i]))
          entries[i].complete <= 1'b1;
        if (rollback_en && squash[i]) begin
          entries[i].valid    <= 1'b0;
          entries[i].complete <= 1'b0;
        end
      end
      for (int l = 0; l < NUM_SUPER; l++)
        if (retire_en[l]) begin
          entries[ret_ptr[l]].valid    <= 1'b0;
          entries[ret_ptr[l]].complete <= 1'b0;
        end
      if (do_dispatch)
        for (int s = 0; s < NUM_SUPER; s++)
          if (dispatch_valid[s]) entries[slot_ptr[s]] <= new_entry[s];
      head  <= head + ROB_W'(ret_cnt);
      tail  <= tail_nx;
      count <= count_nx;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: stimulus pushes expected retirements into
// a queue in program order; a negedge monitor pops and compares every retire.
module tb_reorder_buffer;

  typedef struct packed {
    logic [5:0] T;
    logic [5:0] Told;
    logic [4:0] dest;
  } exp_t;

  logic            clock = 1'b0;
  logic            reset;
  logic            dispatch_en;
  logic [1:0]      dispatch_valid;
  logic [1:0][4:0] dest_idx;
  logic [1:0][5:0] T_idx, Told_idx;
  logic [1:0][4:0] FL_idx;
  logic [1:0]      complete_en;
  logic [1:0][2:0] complete_idx;
  logic            rollback_en;
  logic [2:0]      rollback_idx;
  logic            ROB_valid;
  logic [1:0][2:0] ROB_idx;
  logic [1:0]      retire_en;
  logic [1:0][5:0] retire_Told_idx, retire_T_idx;
  logic [1:0][4:0] retire_dest_idx;
  logic [4:0]      FL_rollback_idx;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  reorder_buffer dut (
    .clock(clock), .reset(reset),
    .dispatch_en(dispatch_en), .dispatch_valid(dispatch_valid),
    .dest_idx(dest_idx), .T_idx(T_idx), .Told_idx(Told_idx), .FL_idx(FL_idx),
    .complete_en(complete_en), .complete_idx(complete_idx),
    .rollback_en(rollback_en), .rollback_idx(rollback_idx),
    .ROB_valid(ROB_valid), .ROB_idx(ROB_idx), .retire_en(retire_en),
    .retire_Told_idx(retire_Told_idx), .retire_T_idx(retire_T_idx),
    .retire_dest_idx(retire_dest_idx), .FL_rollback_idx(FL_rollback_idx)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge and clear one-cycle strobes.
  task automatic step();
    @(posedge clock);
    #1;
    dispatch_en    = 1'b0;
    dispatch_valid = 2'b00;
    complete_en    = 2'b00;
    rollback_en    = 1'b0;
  endtask

  task automatic disp(input logic [1:0] v, input logic [4:0] d0, input logic [4:0] d1,
                      input logic [5:0] t0, input logic [5:0] t1,
                      input logic [5:0] o0, input logic [5:0] o1,
                      input logic [4:0] f0, input logic [4:0] f1, input bit push);
    dispatch_en    = 1'b1;
    dispatch_valid = v;
    dest_idx[0] = d0;  dest_idx[1] = d1;
    T_idx[0]    = t0;  T_idx[1]    = t1;
    Told_idx[0] = o0;  Told_idx[1] = o1;
    FL_idx[0]   = f0;  FL_idx[1]   = f1;
    if (push && v[0]) exp_q.push_back('{T: t0, Told: o0, dest: d0});
    if (push && v[1]) exp_q.push_back('{T: t1, Told: o1, dest: d1});
  endtask

  task automatic comp(input logic [1:0] en, input logic [2:0] i0, input logic [2:0] i1);
    complete_en     = en;
    complete_idx[0] = i0;
    complete_idx[1] = i1;
  endtask

  // Scoreboard monitor: every retiring lane must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      if (retire_en == 2'b10) begin
        errors++;
        $display("FAIL retire_en_shape: got %b, expected 00/01/11", retire_en);
      end
      for (int l = 0; l < 2; l++) begin
        if (retire_en[l]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_retire lane %0d: got T %0d, expected no retire",
                     l, retire_T_idx[l]);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("retire_T",    int'(retire_T_idx[l]),    int'(e.T));
            chk("retire_Told", int'(retire_Told_idx[l]), int'(e.Told));
            chk("retire_dest", int'(retire_dest_idx[l]), int'(e.dest));
          end
        end else begin
          chk("idle_Told", int'(retire_Told_idx[l]), 31);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    dispatch_en = 1'b0; dispatch_valid = '0; dest_idx = '0; T_idx = '0;
    Told_idx = '0; FL_idx = '0; complete_en = '0; complete_idx = '0;
    rollback_en = 1'b0; rollback_idx = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    dispatch_valid = 2'b11;
    @(negedge clock);
    chk("rst_ROB_valid", int'(ROB_valid), 1);
    chk("rst_retire_en", int'(retire_en), 0);
    chk("rst_Told0", int'(retire_Told_idx[0]), 31);
    chk("rst_Told1", int'(retire_Told_idx[1]), 31);
    chk("rst_FL_rollback", int'(FL_rollback_idx), 0);
    chk("rst_ROB_idx0", int'(ROB_idx[0]), 0);
    chk("rst_ROB_idx1", int'(ROB_idx[1]), 1);

    // Dual dispatch, dual complete, dual retire
    step(); disp(2'b11, 1, 2, 32, 33, 1, 2, 1, 2, 1);
    @(negedge clock); chk("d1_ROB_idx0", int'(ROB_idx[0]), 0); chk("d1_ROB_idx1", int'(ROB_idx[1]), 1);
    step(); comp(2'b11, 0, 1);
    @(negedge clock); chk("cmp_same_cycle_no_retire", int'(retire_en), 0);
    step();
    @(negedge clock); chk("dual_retire", int'(retire_en), 3);
    step(); dispatch_valid = 2'b01;
    @(negedge clock); chk("tail_after_retire", int'(ROB_idx[0]), 2);

    // Younger completes first: must wait for head
    step(); disp(2'b11, 3, 4, 34, 35, 3, 4, 3, 4, 1);
    @(negedge clock); chk("d2_ROB_idx0", int'(ROB_idx[0]), 2); chk("d2_ROB_idx1", int'(ROB_idx[1]), 3);
    step(); comp(2'b01, 3, 0);
    @(negedge clock); chk("ooo_wait_a", int'(retire_en), 0);
    step();
    @(negedge clock); chk("ooo_wait_b", int'(retire_en), 0);
    step(); comp(2'b01, 2, 0);
    @(negedge clock); chk("ooo_wait_c", int'(retire_en), 0);
    step();
    @(negedge clock); chk("ooo_retire", int'(retire_en), 3);

    // Fill with wrap: head = tail = 4
    step(); disp(2'b11, 5, 6, 36, 37, 5, 6, 5, 6, 1);
    @(negedge clock); chk("f_idx0", int'(ROB_idx[0]), 4); chk("f_idx1", int'(ROB_idx[1]), 5);
    step(); disp(2'b11, 7, 8, 38, 39, 7, 8, 7, 8, 1);
    @(negedge clock); chk("f_idx2", int'(ROB_idx[0]), 6); chk("f_idx3", int'(ROB_idx[1]), 7);
    step(); disp(2'b10, 0, 9, 0, 40, 0, 9, 0, 9, 1);
    @(negedge clock); chk("wrap_slot1_only", int'(ROB_idx[1]), 0);
    step(); disp(2'b11, 10, 11, 41, 42, 10, 11, 10, 11, 1);
    @(negedge clock); chk("wrap_idx0", int'(ROB_idx[0]), 1); chk("wrap_idx1", int'(ROB_idx[1]), 2);
    chk("cnt5_ROB_valid", int'(ROB_valid), 1);
    step(); comp(2'b11, 4, 5);
    @(negedge clock); chk("cnt7_ROB_valid", int'(ROB_valid), 0);
    step();
    @(negedge clock); chk("cnt7_ROB_valid_b", int'(ROB_valid), 0); chk("full_retire", int'(retire_en), 3);
    step(); comp(2'b11, 6, 7);
    @(negedge clock); chk("cnt5_ROB_valid_b", int'(ROB_valid), 1);
    step(); comp(2'b11, 0, 1);
    step(); comp(2'b01, 2, 0);
    step();
    @(negedge clock); chk("single_retire", int'(retire_en), 1);
    step();
    @(negedge clock); chk("drain_idle", int'(retire_en), 0); chk("drain_q_empty", exp_q.size(), 0);

    // Reset while a dual retire is ready
    step(); disp(2'b11, 1, 2, 43, 44, 3, 4, 1, 2, 1);
    step(); comp(2'b11, 3, 4);
    step(); reset = 1'b1; exp_q.delete();
    @(negedge clock); chk("reset_blocks_retire", int'(retire_en), 0); chk("reset_Told0", int'(retire_Told_idx[0]), 31);
    step(); reset = 1'b0; dispatch_valid = 2'b11;
    @(negedge clock); chk("post_rst_idx0", int'(ROB_idx[0]), 0); chk("post_rst_ROB_valid", int'(ROB_valid), 1);

    // Rollback at entry 2 of six
    step(); disp(2'b11, 1, 2, 40, 41, 10, 11, 3, 4, 1);
    step(); disp(2'b11, 3, 4, 42, 43, 12, 13, 5, 6, 1);
    step(); disp(2'b11, 5, 6, 44, 45, 14, 15, 7, 8, 1);
    step(); rollback_en = 1'b1; rollback_idx = 3'd2;
    disp(2'b11, 9, 9, 60, 61, 1, 1, 1, 1, 0);
    comp(2'b11, 4, 1);
    repeat (3) void'(exp_q.pop_back());
    @(negedge clock); chk("FL_rollback_idx", int'(FL_rollback_idx), 5);
    step(); dispatch_valid = 2'b11; comp(2'b01, 4, 0);
    @(negedge clock); chk("rb_tail_idx0", int'(ROB_idx[0]), 3); chk("rb_tail_idx1", int'(ROB_idx[1]), 4);
    step(); disp(2'b11, 7, 8, 50, 51, 20, 21, 9, 10, 1);
    @(negedge clock); chk("redisp_idx0", int'(ROB_idx[0]), 3);
    step(); comp(2'b11, 0, 2);
    step(); comp(2'b01, 3, 0);
    step();
    step();
    @(negedge clock); chk("redisp4_incomplete", int'(retire_en), 0); chk("q_one_pending", exp_q.size(), 1);
    step(); comp(2'b11, 4, 5);
    step();
    @(negedge clock); chk("last_retire", int'(retire_en), 1);
    step(); disp(2'b01, 12, 0, 52, 0, 22, 0, 11, 0, 1);
    @(negedge clock); chk("slot5_idx", int'(ROB_idx[0]), 5);
    step();
    @(negedge clock); chk("slot5_not_complete", int'(retire_en), 0);
    step(); comp(2'b01, 5, 0);
    step();
    step();
    @(negedge clock); chk("final_q_empty", exp_q.size(), 0); chk("final_idle", int'(retire_en), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
